// File: rtl/mdp3_pkg.sv
// Shared types and defaults for the MDP3 feed arbitration path.
package mdp3_pkg;

  localparam int DEF_DATA_W        = 64;
  localparam int DEF_BEATS_PER_MSG = 5;
  localparam int BEAT_CNT_W        = 8;
  localparam int GRANT_W           = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mdp3_rr_pick.sv
// Combinational round-robin picker: first requester after last grant wins.
module mdp3_rr_pick
  import mdp3_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] winner,
  output logic               found
);

  // Walk from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) begin
        winner = GRANT_W'(idx);
        found  = 1'b1;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/mdp3_feed_arbiter.sv
// Round-robin arbiter forwarding whole MDP3 messages from channel FIFOs to the
// single parser, with a per-grant stall watchdog.
module mdp3_feed_arbiter
  import mdp3_pkg::*;
#(
  parameter int NUM_FEEDS     = 4,
  parameter int BEATS_PER_MSG = DEF_BEATS_PER_MSG,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int STALL_LIMIT   = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_FEEDS-1:0]        feed_not_empty,
  input  logic [NUM_FEEDS*DATA_W-1:0] feed_data,
  output logic [NUM_FEEDS-1:0]        feed_rd_en,
  input  logic                        parser_ready,
  output logic                        par_not_empty,
  output logic [DATA_W-1:0]           par_message,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        busy,
  output logic                        abort_pulse,
  output logic [15:0]                 msg_count
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  arb_state_t         state_r;
  logic [BEAT_CNT_W-1:0] beat_cnt_r;
  logic [STALL_W-1:0]    stall_cnt_r;

  logic [GRANT_W-1:0] pick_s;
  logic               found_s;
  logic               granted_ne_s;
  logic [DATA_W-1:0]  head_s;
  logic               pop_s;

  mdp3_rr_pick #(
    .NUM_REQ(NUM_FEEDS)
  ) u_pick (
    .req   (feed_not_empty),
    .last  (grant_id),
    .winner(pick_s),
    .found (found_s)
  );

  // Select the granted feed's status and head word, and form the pop strobe.
  always_comb begin
    granted_ne_s = 1'b0;
    head_s       = '0;
    for (int i = 0; i < NUM_FEEDS; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        granted_ne_s = feed_not_empty[i];
        head_s       = feed_data[i*DATA_W +: DATA_W];
      end else begin
        head_s = head_s;
      end
    end
    // Reset gates the pop so a dropped message never loses another word.
    pop_s = !reset && (state_r == STREAM) && parser_ready && granted_ne_s;
    for (int i = 0; i < NUM_FEEDS; i++) begin
      if (pop_s && (grant_id == GRANT_W'(i))) begin
        feed_rd_en[i] = 1'b1;
      end else begin
        feed_rd_en[i] = 1'b0;
      end
    end
  end

  // Arbitration, beat forwarding, message accounting and stall watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      beat_cnt_r    <= '0;
      stall_cnt_r   <= '0;
      par_not_empty <= 1'b0;
      par_message   <= '0;
      grant_id      <= GRANT_W'(NUM_FEEDS - 1);
      busy          <= 1'b0;
      abort_pulse   <= 1'b0;
      msg_count     <= 16'd0;
    end else begin
      abort_pulse   <= 1'b0;
      par_not_empty <= pop_s;
      if (pop_s) begin
        par_message <= head_s;
      end
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_id <= pick_s;
            busy     <= 1'b1;
            state_r  <= STREAM;
          end
        end
        STREAM: begin
          if (pop_s) begin
            stall_cnt_r <= '0;
            if (beat_cnt_r == BEAT_CNT_W'(BEATS_PER_MSG - 1)) begin
              beat_cnt_r <= '0;
              msg_count  <= msg_count + 16'd1;
              busy       <= 1'b0;
              state_r    <= IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_CNT_W'(1);
            end
          end else if (!granted_ne_s) begin
            // Expire on the cycle the empty run reaches the limit.
            if (stall_cnt_r == STALL_W'(STALL_LIMIT - 1)) begin
              abort_pulse <= 1'b1;
              beat_cnt_r  <= '0;
              stall_cnt_r <= '0;
              busy        <= 1'b0;
              state_r     <= IDLE;
            end else begin
              stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdp3_feed_arbiter.sv
// Randomised and directed bench for mdp3_feed_arbiter against a queue-based model.
module tb_mdp3_feed_arbiter;

  localparam int NF  = 4;
  localparam int BPM = 5;
  localparam int DW  = 64;
  localparam int SL  = 8;

  typedef logic [63:0] word_q_t[$];

  logic              clk = 1'b0;
  logic              reset;
  logic [NF-1:0]     feed_not_empty;
  logic [NF*DW-1:0]  feed_data;
  logic [NF-1:0]     feed_rd_en;
  logic              parser_ready;
  logic              par_not_empty;
  logic [DW-1:0]     par_message;
  logic [2:0]        grant_id;
  logic              busy;
  logic              abort_pulse;
  logic [15:0]       msg_count;

  always #5 clk = ~clk;

  mdp3_feed_arbiter #(
    .NUM_FEEDS(NF), .BEATS_PER_MSG(BPM), .DATA_W(DW), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset), .feed_not_empty(feed_not_empty), .feed_data(feed_data),
    .feed_rd_en(feed_rd_en), .parser_ready(parser_ready), .par_not_empty(par_not_empty),
    .par_message(par_message), .grant_id(grant_id), .busy(busy),
    .abort_pulse(abort_pulse), .msg_count(msg_count)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  word_q_t     fq[NF];
  logic [NF-1:0] vis;

  // Behavioural model state
  bit          m_busy;
  int          m_g;
  int          m_beats;
  int          m_stall;
  logic [15:0] m_count;
  logic        m_pne;
  logic [63:0] m_msg;
  logic        m_abort;

  // Observations of DUT outputs for the literal expectations
  logic [63:0] cap_words[$];
  int          cap_cycles[$];
  int          grants[$];
  int          abort_cnt;
  int          last_abort_cycle;
  logic [15:0] count_at_abort;
  logic        prev_busy;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  function automatic bit ne_of(int f);
    return ((feed_not_empty >> f) & NF'(1)) != NF'(0);
  endfunction

  function automatic void drive_feeds();
    for (int i = 0; i < NF; i++) begin
      feed_not_empty[i] = (fq[i].size() > 0) && vis[i];
      feed_data[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : 64'd0;
    end
  endfunction

  // One clock: predict this cycle's pop, advance the model, compare all outputs.
  task automatic step();
    logic [NF-1:0] exp_rd;
    int pop_feed;
    drive_feeds();
    #1;
    exp_rd   = '0;
    pop_feed = -1;
    m_pne    = 1'b0;
    m_abort  = 1'b0;
    if (reset) begin
      m_busy = 0; m_beats = 0; m_stall = 0; m_count = 16'd0; m_g = NF - 1; m_msg = 64'd0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NF; k++) begin
        if (ne_of((m_g + k) % NF)) begin
          m_g = (m_g + k) % NF;
          m_busy = 1;
          break;
        end
      end
    end else if (parser_ready && ne_of(m_g)) begin
      pop_feed = m_g;
      exp_rd   = NF'(1) << m_g;
      m_pne    = 1'b1;
      m_msg    = fq[m_g][0];
      m_stall  = 0;
      m_beats++;
      if (m_beats == BPM) begin
        m_beats = 0;
        m_count = m_count + 16'd1;
        m_busy  = 0;
      end
    end else if (!ne_of(m_g)) begin
      m_stall++;
      if (m_stall == SL) begin
        m_abort = 1'b1;
        m_busy  = 0;
        m_beats = 0;
        m_stall = 0;
      end
    end
    check("feed_rd_en", 64'(feed_rd_en), 64'(exp_rd));
    if (pop_feed >= 0) void'(fq[pop_feed].pop_front());
    @(negedge clk);
    cycle++;
    check("par_not_empty", 64'(par_not_empty), 64'(m_pne));
    check("par_message", par_message, m_msg);
    check("grant_id", 64'(grant_id), 64'(m_g));
    check("busy", 64'(busy), 64'(m_busy));
    check("abort_pulse", 64'(abort_pulse), 64'(m_abort));
    check("msg_count", 64'(msg_count), 64'(m_count));
    if (par_not_empty) begin
      cap_words.push_back(par_message);
      cap_cycles.push_back(cycle);
    end
    if (abort_pulse) begin
      abort_cnt++;
      last_abort_cycle = cycle;
      count_at_abort   = msg_count;
    end
    if (busy && !prev_busy) grants.push_back(int'(grant_id));
    prev_busy = busy;
  endtask

  task automatic clear_all();
    for (int f = 0; f < NF; f++) fq[f].delete();
    cap_words.delete();
    cap_cycles.delete();
    grants.delete();
    abort_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cap_words.delete();
    cap_cycles.delete();
    grants.delete();
    abort_cnt = 0;
  endtask

  initial begin
    int rel;
    int n;
    reset = 1'b1; parser_ready = 1'b0; vis = '1;
    feed_not_empty = '0; feed_data = '0;
    m_busy = 0; m_g = NF - 1; m_beats = 0; m_stall = 0; m_count = 16'd0;
    m_msg = 64'd0; m_pne = 1'b0; m_abort = 1'b0; prev_busy = 1'b0;
    abort_cnt = 0; last_abort_cycle = 0; count_at_abort = 16'd0;
    @(negedge clk);
    clear_all();
    do_reset();

    // Single feed, five beats
    parser_ready = 1'b1;
    for (int j = 0; j < BPM; j++) fq[0].push_back(64'h11 + 64'(j));
    rel = cycle;
    repeat (8) step();
    check("t1_beats", 64'(cap_words.size()), 64'd5);
    check("t1_first_latency", 64'(cap_cycles.size() > 0 ? cap_cycles[0] - rel : -1), 64'd2);
    for (int j = 0; j < cap_words.size(); j++) check("t1_word", cap_words[j], 64'h11 + 64'(j));
    check("t1_msg_count", 64'(msg_count), 64'd1);
    check("t1_grant", 64'(grant_id), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // Fairness, two messages per feed
    clear_all(); do_reset();
    parser_ready = 1'b1;
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < 2 * BPM; k++) fq[f].push_back(64'((f + 1) * 256 + k));
    repeat (8 * (BPM + 1) + 6) step();
    check("t2_grants", 64'(grants.size()), 64'd8);
    for (int m = 0; m < grants.size(); m++) check("t2_grant_order", 64'(grants[m]), 64'(m % 4));
    check("t2_beats", 64'(cap_words.size()), 64'd40);
    for (int b = 0; b < cap_words.size(); b++)
      check("t2_word", cap_words[b], 64'(((b / 5) % 4 + 1) * 256 + ((b / 5) / 4) * 5 + b % 5));
    for (int m = 1; m < 8 && 5 * m < cap_cycles.size(); m++)
      check("t2_idle_gap", 64'(cap_cycles[5 * m] - cap_cycles[5 * m - 1]), 64'd2);
    check("t2_msg_count", 64'(msg_count), 64'd8);

    // Backpressure toggling
    clear_all(); do_reset();
    for (int j = 0; j < BPM; j++) fq[0].push_back(64'h31 + 64'(j));
    parser_ready = 1'b0;
    repeat (16) begin
      parser_ready = ~parser_ready;
      step();
    end
    check("t3_beats", 64'(cap_words.size()), 64'd5);
    for (int j = 0; j < cap_words.size(); j++) check("t3_word", cap_words[j], 64'h31 + 64'(j));
    check("t3_no_abort", 64'(abort_cnt), 64'd0);
    check("t3_msg_count", 64'(msg_count), 64'd1);

    // Watchdog: feed 2 stops after three beats, feed 3 waits
    clear_all(); do_reset();
    parser_ready = 1'b1;
    for (int j = 0; j < 3; j++) fq[2].push_back(64'h41 + 64'(j));
    for (int j = 0; j < BPM; j++) fq[3].push_back(64'h51 + 64'(j));
    repeat (22) step();
    check("t4_abort_cnt", 64'(abort_cnt), 64'd1);
    check("t4_abort_delay", 64'(cap_cycles.size() > 2 ? last_abort_cycle - cap_cycles[2] : -1), 64'd8);
    check("t4_count_at_abort", 64'(count_at_abort), 64'd0);
    check("t4_grants", 64'(grants.size()), 64'd2);
    for (int m = 0; m < grants.size(); m++) check("t4_grant_seq", 64'(grants[m]), 64'(m + 2));
    check("t4_msg_count", 64'(msg_count), 64'd1);

    // Reset in the middle of a message
    clear_all(); do_reset();
    parser_ready = 1'b1;
    for (int j = 0; j < BPM; j++) fq[1].push_back(64'h61 + 64'(j));
    n = 0;
    while (cap_words.size() < 2 && n < 20) begin
      step();
      n++;
    end
    check("t5_two_beats", 64'(cap_words.size()), 64'd2);
    reset = 1'b1;
    for (int j = 0; j < BPM; j++) fq[0].push_back(64'h71 + 64'(j));
    step();
    check("t5_rst_pne", 64'(par_not_empty), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_grant", 64'(grant_id), 64'd3);
    check("t5_feed1_left", 64'(fq[1].size()), 64'd3);
    reset = 1'b0;
    grants.delete();
    repeat (8) step();
    check("t5_first_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);

    // msg_count wrap
    clear_all(); do_reset();
    force dut.msg_count = 16'hFFFF;
    #1;
    release dut.msg_count;
    m_count = 16'hFFFF;
    parser_ready = 1'b1;
    for (int j = 0; j < BPM; j++) fq[0].push_back(64'h81 + 64'(j));
    repeat (8) step();
    check("t6_wrap", 64'(msg_count), 64'd0);

    // Random traffic, backpressure, gaps and occasional reset
    clear_all(); do_reset();
    for (int c = 0; c < 3000; c++) begin
      parser_ready = ($urandom_range(3) != 0);
      for (int f = 0; f < NF; f++) begin
        vis[f] = ($urandom_range(7) != 0);
        if ($urandom_range(4) == 0) fq[f].push_back({$urandom, $urandom});
      end
      reset = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
